// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types and branch-predictor counter constants.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Counter midpoints. An entry predicts taken when its counter MSB is set,
  // so weak-taken is the smallest value with the MSB set and weak-not-taken
  // is the largest value without it.
  function automatic int ctr_weak_t(input int ctr_w);
    return 1 << (ctr_w - 1);
  endfunction

  function automatic int ctr_weak_nt(input int ctr_w);
    return (1 << (ctr_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.vh
// branch_predictor_if: bundle between the predictor and the datapath.
// Latency: n/a (wires only).
// Backpressure: n/a; the datapath stalls training by holding upd_en low.
// Modports: bp = predictor side, dp = datapath (fetch, EX/MEM, hazard unit).
`ifndef BRANCH_PREDICTOR_IF_VH
`define BRANCH_PREDICTOR_IF_VH

interface branch_predictor_if;
  import cpu_types_pkg::*;

  // fetch side
  word_t fetch_pc;
  logic  pred_taken;
  word_t pred_target;

  // resolve side
  logic  upd_valid;
  logic  upd_en;
  word_t upd_pc;
  logic  upd_is_jump;
  logic  upd_taken;
  word_t upd_target;
  logic  upd_pred_taken;
  word_t upd_pred_target;
  logic  mispredict;
  word_t redirect_pc;

  // statistics
  word_t stat_lookups;
  word_t stat_misses;

  modport bp (
    input  fetch_pc, upd_valid, upd_en, upd_pc, upd_is_jump, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc,
           stat_lookups, stat_misses
  );

  modport dp (
    output fetch_pc, upd_valid, upd_en, upd_pc, upd_is_jump, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc,
           stat_lookups, stat_misses
  );
endinterface

`endif

// File: rtl/sat_counter.sv
// sat_counter: next value of an up/down counter that saturates at 0 and all-ones.
// Latency: combinational.
// Backpressure: none.
// Ports: ctr = current value, inc = 1 count up / 0 count down, ctr_nxt = result.
module sat_counter #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             inc,
  output logic [CTR_W-1:0] ctr_nxt
);

  localparam logic [CTR_W-1:0] ONE = CTR_W'(1);

  always_comb begin
    ctr_nxt = ctr;
    if (inc) begin
      if (ctr != '1) ctr_nxt = ctr + ONE;
    end else begin
      if (ctr != '0) ctr_nxt = ctr - ONE;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with bimodal counters beside the PC.
// Latency: lookup and mispredict are combinational; table writes visible next cycle.
// Backpressure: state changes only when upd_valid & upd_en (pipeline advancing).
// Ports: fetch_pc -> pred_taken/pred_target (fetch); upd_* from EX/MEM ->
//        mispredict/redirect_pc (hazard unit); stat_* saturating counters.
module branch_predictor
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int MODE    = 1
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t fetch_pc,
  output logic  pred_taken,
  output word_t pred_target,
  input  logic  upd_valid,
  input  logic  upd_en,
  input  word_t upd_pc,
  input  logic  upd_is_jump,
  input  logic  upd_taken,
  input  word_t upd_target,
  input  logic  upd_pred_taken,
  input  word_t upd_pred_target,
  output logic  mispredict,
  output word_t redirect_pc,
  output word_t stat_lookups,
  output word_t stat_misses
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(ctr_weak_t(CTR_W));
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'(ctr_weak_nt(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX     = '1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            target;
    logic             is_jump;
    logic [CTR_W-1:0] ctr;
  } btb_entry_t;

  localparam btb_entry_t RST_ENT = '{
    valid: 1'b0, tag: '0, target: '0, is_jump: 1'b0, ctr: CTR_WEAK_NT
  };

  btb_entry_t tbl [0:ENTRIES-1];

  // ---------------- fetch lookup ----------------
  logic [IDX_W-1:0] f_idx;
  btb_entry_t       f_ent;
  logic             f_hit;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_ent = tbl[f_idx];
  assign f_hit = f_ent.valid && (f_ent.tag == fetch_pc[31:IDX_W+2]);

  // The MODE gate keeps static not-taken explicit even though the table
  // stays invalid in that mode anyway.
  assign pred_taken  = (MODE != 0) && f_hit && (f_ent.is_jump || f_ent.ctr[CTR_W-1]);
  assign pred_target = pred_taken ? f_ent.target : fetch_pc + 32'd4;

  // ---------------- resolve / mispredict ----------------
  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

  // ---------------- training ----------------
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  btb_entry_t       u_ent;
  logic             u_hit;
  logic             upd_q;
  logic [CTR_W-1:0] ctr_nxt;
  logic             wr_en;
  btb_entry_t       wr_ent;

  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[31:IDX_W+2];
  assign u_ent = tbl[u_idx];
  assign u_hit = u_ent.valid && (u_ent.tag == u_tag);
  assign upd_q = upd_valid && upd_en;

  sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
    .ctr     (u_ent.ctr),
    .inc     (upd_taken),
    .ctr_nxt (ctr_nxt)
  );

  always_comb begin
    wr_en  = 1'b0;
    wr_ent = u_ent;
    if ((MODE != 0) && upd_q) begin
      if (u_hit) begin
        wr_en          = 1'b1;
        if (upd_taken) wr_ent.target = upd_target;
        wr_ent.is_jump = upd_is_jump;
        wr_ent.ctr     = ctr_nxt;
      end else if (upd_taken) begin
        // Not-taken misses are not allocated: they would only evict a
        // useful entry to record the default prediction.
        wr_en          = 1'b1;
        wr_ent.valid   = 1'b1;
        wr_ent.tag     = u_tag;
        wr_ent.target  = upd_target;
        wr_ent.is_jump = upd_is_jump;
        wr_ent.ctr     = upd_is_jump ? CTR_MAX : CTR_WEAK_T;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= RST_ENT;
    end else if (wr_en) begin
      tbl[u_idx] <= wr_ent;
    end
  end

  // ---------------- statistics ----------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_lookups <= '0;
      stat_misses  <= '0;
    end else begin
      if (upd_q && (stat_lookups != '1)) stat_lookups <= stat_lookups + 32'd1;
      if (upd_q && mispredict && (stat_misses != '1)) stat_misses <= stat_misses + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and random checks of branch_predictor against a
// behavioural BTB model; a second instance runs static not-taken mode.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] fetch_pc = '0, upd_pc = '0, upd_target = '0, upd_pred_target = '0;
  logic        upd_valid = 1'b0, upd_en = 1'b0, upd_is_jump = 1'b0;
  logic        upd_taken = 1'b0, upd_pred_taken = 1'b0;

  logic        pred_taken, mispredict, pred_taken0, mispredict0;
  logic [31:0] pred_target, redirect_pc, stat_lookups, stat_misses;
  logic [31:0] pred_target0, redirect_pc0, stat_lookups0, stat_misses0;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  branch_predictor #(.ENTRIES(16), .CTR_W(2), .MODE(1)) dut (
    .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_lookups(stat_lookups), .stat_misses(stat_misses)
  );

  branch_predictor #(.ENTRIES(16), .CTR_W(2), .MODE(0)) dut_static (
    .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken0), .pred_target(pred_target0),
    .upd_valid(upd_valid), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict0), .redirect_pc(redirect_pc0),
    .stat_lookups(stat_lookups0), .stat_misses(stat_misses0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: 16-entry table, 2-bit counters ----------------
  bit          m_v   [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  bit          m_j   [16];
  int          m_ctr [16];
  logic [31:0] m_look, m_miss;

  function automatic int m_slot(input logic [31:0] pc);
    return int'((pc >> 2) % 32'd16);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_j[i] = 0; m_ctr[i] = 1;
    end
    m_look = '0;
    m_miss = '0;
  endtask

  function automatic bit m_pred(input logic [31:0] pc, output logic [31:0] t);
    int  i = m_slot(pc);
    bit  hit = m_v[i] && (m_tag[i] == (pc >> 6));
    bit  p = hit && (m_j[i] || m_ctr[i] >= 2);
    t = p ? m_tgt[i] : pc + 32'd4;
    return p;
  endfunction

  task automatic m_train(input logic [31:0] pc, input bit isj, input bit tk, input logic [31:0] tgt);
    int i = m_slot(pc);
    if (m_v[i] && m_tag[i] == (pc >> 6)) begin
      if (tk) m_tgt[i] = tgt;
      m_j[i]   = isj;
      m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
    end else if (tk) begin
      m_v[i] = 1; m_tag[i] = pc >> 6; m_tgt[i] = tgt; m_j[i] = isj;
      m_ctr[i] = isj ? 3 : 2;
    end
  endtask

  // ---------------- one cycle of stimulus + checks ----------------
  bit          obs_pt, obs_mp;
  logic [31:0] obs_ptgt, obs_rpc;

  task automatic cyc(input logic [31:0] fpc, input bit uv, input bit ue,
                     input logic [31:0] upc, input bit isj, input bit tk,
                     input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    bit          ept, emp;
    logic [31:0] etgt, erpc;
    @(negedge CLK);
    fetch_pc = fpc; upd_valid = uv; upd_en = ue; upd_pc = upc; upd_is_jump = isj;
    upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    #1;
    ept  = m_pred(fpc, etgt);
    emp  = uv && ((tk != ptk) || (tk && tgt != ptgt));
    erpc = tk ? tgt : upc + 32'd4;
    obs_pt = pred_taken; obs_ptgt = pred_target; obs_mp = mispredict; obs_rpc = redirect_pc;
    chk("pred_taken",     {31'd0, pred_taken},  {31'd0, ept});
    chk("pred_target",    pred_target,          etgt);
    chk("mispredict",     {31'd0, mispredict},  {31'd0, emp});
    chk("redirect_pc",    redirect_pc,          erpc);
    chk("s_pred_taken",   {31'd0, pred_taken0}, 32'd0);
    chk("s_pred_target",  pred_target0,         fpc + 32'd4);
    chk("s_mispredict",   {31'd0, mispredict0}, {31'd0, emp});
    if (uv && ue) begin
      m_train(upc, isj, tk, tgt);
      if (m_look != '1) m_look++;
      if (emp && m_miss != '1) m_miss++;
    end
    @(posedge CLK);
    #1;
    chk("stat_lookups",   stat_lookups,  m_look);
    chk("stat_misses",    stat_misses,   m_miss);
    chk("s_stat_lookups", stat_lookups0, m_look);
    chk("s_stat_misses",  stat_misses0,  m_miss);
  endtask

  task automatic idle(input logic [31:0] fpc);
    cyc(fpc, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] fpc, input logic [31:0] upc, input bit isj,
                     input bit tk, input logic [31:0] tgt, input bit ptk,
                     input logic [31:0] ptgt);
    cyc(fpc, 1, 1, upc, isj, tk, tgt, ptk, ptgt);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 31) == 0) pc = 32'hFFFF_FFFC;
    else pc = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
    return pc;
  endfunction

  task automatic rand_cycles(input int n);
    logic [31:0] fpc, upc, tgt, ptgt;
    bit          uv, ue, isj, tk, ptk;
    for (int k = 0; k < n; k++) begin
      fpc = rand_pc();
      upc = rand_pc();
      tgt = $urandom & 32'hFFFF_FFFC;
      isj = ($urandom_range(0, 4) == 0);
      tk  = isj ? 1'b1 : 1'($urandom_range(0, 1));
      uv  = ($urandom_range(0, 3) != 0);
      ue  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) != 0) ptk = m_pred(upc, ptgt);
      else begin
        ptk  = 1'($urandom_range(0, 1));
        ptgt = $urandom & 32'hFFFF_FFFC;
      end
      cyc(fpc, uv, ue, upc, isj, tk, tgt, ptk, ptgt);
    end
  endtask

  initial begin
    m_reset();
    #3;
    chk("rst_lookups_async", stat_lookups, 32'd0);
    chk("rst_misses_async",  stat_misses,  32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // reset state
    idle(32'h100);
    chk("tp_reset_pt",   {31'd0, obs_pt}, 32'd0);
    chk("tp_reset_tgt",  obs_ptgt, 32'h104);

    // first taken branch: allocate, mispredict, no same-cycle bypass
    upd(32'h100, 32'h100, 0, 1, 32'h200, 0, 32'h104);
    chk("tp_alloc_mp",   {31'd0, obs_mp}, 32'd1);
    chk("tp_alloc_rpc",  obs_rpc, 32'h200);
    chk("tp_no_bypass",  {31'd0, obs_pt}, 32'd0);
    chk("tp_alloc_miss", stat_misses, 32'd1);
    idle(32'h100);
    chk("tp_trained_pt",  {31'd0, obs_pt}, 32'd1);
    chk("tp_trained_tgt", obs_ptgt, 32'h200);

    // not-taken training down to 00, then saturation hold
    upd(32'h100, 32'h100, 0, 0, 32'h0, 1, 32'h200);
    chk("tp_nt_mp",  {31'd0, obs_mp}, 32'd1);
    chk("tp_nt_rpc", obs_rpc, 32'h104);
    idle(32'h100);
    chk("tp_weak_nt_pt", {31'd0, obs_pt}, 32'd0);
    upd(32'h100, 32'h100, 0, 0, 32'h0, 0, 32'h0);
    upd(32'h100, 32'h100, 0, 0, 32'h0, 0, 32'h0);
    upd(32'h100, 32'h100, 0, 1, 32'h200, 0, 32'h104);
    idle(32'h100);
    chk("tp_sat_hold_pt", {31'd0, obs_pt}, 32'd0);

    // aliasing on index 0 of a 16-entry table
    upd(32'h100, 32'h100, 0, 1, 32'h200, 0, 32'h104);
    idle(32'h140);
    chk("tp_alias_pt",  {31'd0, obs_pt}, 32'd0);
    chk("tp_alias_tgt", obs_ptgt, 32'h144);
    upd(32'h140, 32'h140, 0, 1, 32'h300, 0, 32'h144);
    idle(32'h100);
    chk("tp_evicted_pt", {31'd0, obs_pt}, 32'd0);
    idle(32'h140);
    chk("tp_new_tgt", obs_ptgt, 32'h300);

    // unconditional jump, then a correct prediction
    upd(32'h80, 32'h80, 1, 1, 32'h400, 0, 32'h84);
    idle(32'h80);
    chk("tp_jump_tgt", obs_ptgt, 32'h400);
    upd(32'h80, 32'h80, 1, 1, 32'h400, 1, 32'h400);
    chk("tp_jump_ok_mp", {31'd0, obs_mp}, 32'd0);

    // held update: upd_valid without upd_en changes nothing
    cyc(32'h80, 1, 0, 32'h80, 0, 0, 32'h0, 1, 32'h400);

    // address wrap
    idle(32'hFFFF_FFFC);
    chk("tp_wrap_tgt", obs_ptgt, 32'h0);
    upd(32'h0, 32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0);
    chk("tp_wrap_rpc", obs_rpc, 32'h0);

    rand_cycles(500);

    // asynchronous reset in the middle of a cycle
    upd(32'h80, 32'h80, 1, 1, 32'h400, 0, 32'h84);
    @(posedge CLK);
    #2;
    fetch_pc = 32'h80;
    upd_valid = 1'b0;
    nRST = 1'b0;
    #1;
    chk("mid_rst_lookups",   stat_lookups,  32'd0);
    chk("mid_rst_misses",    stat_misses,   32'd0);
    chk("mid_rst_s_lookups", stat_lookups0, 32'd0);
    chk("mid_rst_pt",        {31'd0, pred_taken}, 32'd0);
    chk("mid_rst_tgt",       pred_target, 32'h84);
    m_reset();
    @(negedge CLK);
    nRST = 1'b1;
    rand_cycles(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
